// File: rtl/wrt_buf_d_pkg.sv
// Shared cache constants and the FSM encoding used by the write-back and fill-side buffers.
package wrt_buf_d_pkg;

    localparam int LINE_W = 512;
    localparam int DATA_W = 32;
    localparam int BEATS  = LINE_W / DATA_W;
    localparam int OFS_W  = 6;
    localparam int CNT_W  = $clog2(BEATS);

    // AXI burst length field (beats minus one)
    localparam logic [7:0] AXI_LEN = 8'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } buf_state_e;

endpackage

// File: rtl/wrt_buf_d.sv
// Data-cache write-back buffer: snapshots a dirty victim line and streams it to the
// AXI bridge as one 16-beat burst, lowest word first.
module wrt_buf_d
    import wrt_buf_d_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt_start,
    input  logic [31:0]       wrt_addr,
    input  logic [LINE_W-1:0] wrt_line,
    output logic              wrt_busy,
    output logic              wrt_done,
    output logic              wr_req,
    output logic [31:0]       wr_addr,
    input  logic              wr_rdy,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    output logic              w_last,
    input  logic              w_ready,
    input  logic              b_valid
);

    buf_state_e                   state, state_nxt;
    logic [BEATS-1:0][DATA_W-1:0] line;
    logic [CNT_W-1:0]             count;
    logic [31:0]                  addr;
    logic                         done;
    logic                         accept;
    logic                         beat;

    assign accept = (state == IDLE) && wrt_start;
    assign beat   = (state == DATA) && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            addr  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == RESP) && b_valid;
            if (accept) begin
                addr  <= {wrt_addr[31:OFS_W], {OFS_W{1'b0}}};
                count <= '0;
            end else if (beat) begin
                // wraps to 0 on the final beat, which is also the exit from DATA
                count <= count + 1'b1;
            end
        end
    end

    // Line storage carries no reset; it is only meaningful once captured.
    always_ff @(posedge clk) begin
        if (accept)
            line <= wrt_line;
    end

    always_comb begin
        state_nxt = state;
        wrt_busy  = 1'b1;
        wr_req    = 1'b0;
        w_valid   = 1'b0;
        w_last    = 1'b0;
        w_data    = '0;
        unique case (state)
            IDLE: begin
                wrt_busy = 1'b0;
                if (wrt_start)
                    state_nxt = REQ;
            end
            REQ: begin
                wr_req = 1'b1;
                if (wr_rdy)
                    state_nxt = DATA;
            end
            DATA: begin
                // beat-select mux keeps w_data steady under backpressure for free
                w_valid = 1'b1;
                w_data  = line[count];
                w_last  = (count == CNT_W'(BEATS - 1));
                if (w_ready && w_last)
                    state_nxt = RESP;
            end
            RESP: begin
                if (b_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_addr  = addr;
    assign wrt_done = done;

endmodule
